// File: rtl/drive_pkg.sv
// Shared types and constants for the drive scheduler and its command handshake.
package drive_pkg;

    typedef enum logic [1:0] {
        ModeStop   = 2'd0,
        ModeManual = 2'd1,
        ModeSearch = 2'd2,
        ModeTrack  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        MotorStop  = 3'd0,
        MotorFwd   = 3'd1,
        MotorBack  = 3'd2,
        MotorLeft  = 3'd3,
        MotorRight = 3'd4
    } motor_cmd_e;

    localparam logic [2:0] IR_NONE   = 3'd0;
    localparam logic [2:0] IR_FWD    = 3'd1;
    localparam logic [2:0] IR_BACK   = 3'd2;
    localparam logic [2:0] IR_LEFT   = 3'd3;
    localparam logic [2:0] IR_RIGHT  = 3'd4;
    localparam logic [2:0] IR_STOP   = 3'd5;
    localparam logic [2:0] IR_AUTO   = 3'd6;
    localparam logic [2:0] IR_MANUAL = 3'd7;

    localparam logic [2:0] DIR_LEFT   = 3'b100;
    localparam logic [2:0] DIR_CENTRE = 3'b010;
    localparam logic [2:0] DIR_RIGHT  = 3'b001;

    // Command word is {motion, speed}.
    localparam int unsigned CmdW = 4;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/cmd_handshake.sv
// Registered valid/ready command port: offers a new word only when it differs
// from the last accepted one, and freezes while the receiver stalls.
module cmd_handshake #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] desired_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic [Width-1:0] last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (valid_q) begin
            if (ready_i) begin
                last_d  = data_q;
                valid_d = 1'b0;
            end
        end else if (desired_i != last_q) begin
            data_d  = desired_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/drive_scheduler.sv
// Motion mode controller: arbitrates IR remote, target classifier and loudness
// flag, and is the sole originator of motor commands.
module drive_scheduler
    import drive_pkg::*;
#(
    parameter int unsigned MANUAL_TIMEOUT = 50_000_000,
    parameter int unsigned CONFIRM_FRAMES = 3,
    parameter int unsigned LOST_FRAMES    = 8
) (
    input  logic       clk,
    input  logic       resend,
    input  logic [2:0] ir_cmd,
    input  logic       ir_toggle,
    input  logic       frame_tick,
    input  logic [2:0] direction,
    input  logic       orange_detected,
    input  logic       fast,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] motor_cmd,
    output logic       speed_fast,
    output logic [1:0] mode
);

    localparam int unsigned TimerW = $clog2(MANUAL_TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(MANUAL_TIMEOUT);
    localparam logic [3:0] ConfirmTarget = 4'(CONFIRM_FRAMES);
    localparam logic [3:0] LostTarget    = 4'(LOST_FRAMES);

    mode_e             mode_q, mode_d;
    motor_cmd_e        motion_q, motion_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        confirm_q, confirm_d;
    logic [3:0]        miss_q, miss_d;
    logic              toggle_q;

    logic       press;
    logic       dir_valid;
    motor_cmd_e dir_motion;
    motor_cmd_e desired_motion;
    logic       desired_speed;
    logic [CmdW-1:0] cmd_data;

    // Code 0 is treated as no press so frame counting proceeds normally.
    assign press = (ir_toggle != toggle_q) && (ir_cmd != IR_NONE);

    always_ff @(posedge clk) begin
        toggle_q <= ir_toggle;
        if (resend) begin
            mode_q    <= ModeStop;
            motion_q  <= MotorStop;
            timer_q   <= '0;
            confirm_q <= '0;
            miss_q    <= '0;
        end else begin
            mode_q    <= mode_d;
            motion_q  <= motion_d;
            timer_q   <= timer_d;
            confirm_q <= confirm_d;
            miss_q    <= miss_d;
        end
    end

    always_comb begin
        dir_valid  = 1'b1;
        dir_motion = MotorFwd;
        case (direction)
            DIR_LEFT:   dir_motion = MotorLeft;
            DIR_CENTRE: dir_motion = MotorFwd;
            DIR_RIGHT:  dir_motion = MotorRight;
            default:    dir_valid  = 1'b0;
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        motion_d  = motion_q;
        timer_d   = timer_q;
        confirm_d = confirm_q;
        miss_d    = miss_q;
        if (press) begin
            // A press overrides any frame event in the same cycle.
            confirm_d = '0;
            miss_d    = '0;
            case (ir_cmd)
                IR_STOP: begin
                    mode_d   = ModeStop;
                    motion_d = MotorStop;
                end
                IR_AUTO: begin
                    mode_d   = ModeSearch;
                    motion_d = MotorRight;
                end
                IR_MANUAL: begin
                    mode_d   = ModeManual;
                    motion_d = MotorStop;
                    timer_d  = '0;
                end
                default: begin
                    mode_d   = ModeManual;
                    motion_d = motor_cmd_e'(ir_cmd);
                    timer_d  = TimerLoad;
                end
            endcase
        end else begin
            unique case (mode_q)
                ModeStop: begin
                    motion_d = MotorStop;
                end
                ModeManual: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TimerW'(1);
                    end else begin
                        motion_d = MotorStop;
                    end
                end
                ModeSearch: begin
                    // Holding right here gives TRACK a sane motion until a direction arrives.
                    motion_d = MotorRight;
                    if (frame_tick) begin
                        if (orange_detected) begin
                            confirm_d = sat_inc4(confirm_q);
                            if (confirm_d >= ConfirmTarget) begin
                                mode_d    = ModeTrack;
                                confirm_d = '0;
                                miss_d    = '0;
                            end
                        end else begin
                            confirm_d = '0;
                        end
                    end
                end
                ModeTrack: begin
                    if (dir_valid) begin
                        motion_d = dir_motion;
                    end
                    if (frame_tick) begin
                        if (!orange_detected) begin
                            miss_d = sat_inc4(miss_q);
                            if (miss_d >= LostTarget) begin
                                mode_d    = ModeSearch;
                                miss_d    = '0;
                                confirm_d = '0;
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        desired_motion = MotorStop;
        desired_speed  = 1'b0;
        unique case (mode_q)
            ModeStop: begin
                desired_motion = MotorStop;
                desired_speed  = 1'b0;
            end
            ModeManual: begin
                desired_motion = motion_q;
                desired_speed  = fast;
            end
            ModeSearch: begin
                desired_motion = MotorRight;
                desired_speed  = 1'b0;
            end
            ModeTrack: begin
                desired_motion = motion_q;
                desired_speed  = fast;
            end
        endcase
    end

    cmd_handshake #(
        .Width(CmdW)
    ) u_cmd_handshake (
        .clk_i    (clk),
        .rst_i    (resend),
        .desired_i({desired_motion, desired_speed}),
        .ready_i  (cmd_ready),
        .valid_o  (cmd_valid),
        .data_o   (cmd_data)
    );

    assign motor_cmd  = cmd_data[3:1];
    assign speed_fast = cmd_data[0];
    assign mode       = mode_q;

endmodule

// File: tb/tb_drive_scheduler.sv
// Directed bench for drive_scheduler with a short manual timeout.
module tb_drive_scheduler;

    logic       clk = 1'b0;
    logic       resend;
    logic [2:0] ir_cmd;
    logic       ir_toggle;
    logic       frame_tick;
    logic [2:0] direction;
    logic       orange_detected;
    logic       fast;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] motor_cmd;
    logic       speed_fast;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    drive_scheduler #(
        .MANUAL_TIMEOUT(10),
        .CONFIRM_FRAMES(3),
        .LOST_FRAMES   (8)
    ) dut (
        .clk            (clk),
        .resend         (resend),
        .ir_cmd         (ir_cmd),
        .ir_toggle      (ir_toggle),
        .frame_tick     (frame_tick),
        .direction      (direction),
        .orange_detected(orange_detected),
        .fast           (fast),
        .cmd_ready      (cmd_ready),
        .cmd_valid      (cmd_valid),
        .motor_cmd      (motor_cmd),
        .speed_fast     (speed_fast),
        .mode           (mode)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] code);
        ir_cmd    = code;
        ir_toggle = ~ir_toggle;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        resend          = 1'b1;
        ir_cmd          = 3'd0;
        ir_toggle       = 1'b0;
        frame_tick      = 1'b0;
        direction       = 3'b000;
        orange_detected = 1'b0;
        fast            = 1'b0;
        cmd_ready       = 1'b0;
        step();
        step();
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_motor", 32'(motor_cmd), 0);
        check("rst_speed", 32'(speed_fast), 0);
        check("rst_mode", 32'(mode), 0);
        resend = 1'b0;

        // Reset while a command is stalled
        press(3'd1);
        step();
        check("t1_mode", 32'(mode), 1);
        step();
        check("t1_valid", 32'(cmd_valid), 1);
        check("t1_motor", 32'(motor_cmd), 1);
        step();
        check("t1_frozen", 32'(cmd_valid), 1);
        resend = 1'b1;
        step();
        check("t1_rst_valid", 32'(cmd_valid), 0);
        check("t1_rst_motor", 32'(motor_cmd), 0);
        check("t1_rst_mode", 32'(mode), 0);
        resend = 1'b0;
        step();
        check("t1_idle", 32'(cmd_valid), 0);

        // Manual press, then timeout back to stop
        cmd_ready = 1'b1;
        fast      = 1'b1;
        press(3'd1);
        step();
        check("t2_mode", 32'(mode), 1);
        step();
        check("t2_valid", 32'(cmd_valid), 1);
        check("t2_motor", 32'(motor_cmd), 1);
        check("t2_speed", 32'(speed_fast), 1);
        repeat (10) step();
        check("t2_pre_timeout", 32'(cmd_valid), 0);
        check("t2_still_manual", 32'(mode), 1);
        step();
        check("t2_to_valid", 32'(cmd_valid), 1);
        check("t2_to_motor", 32'(motor_cmd), 0);
        check("t2_to_speed", 32'(speed_fast), 1);

        // Search confirms into track
        fast = 1'b0;
        press(3'd6);
        step();
        check("t3_mode_search", 32'(mode), 2);
        step();
        check("t3_valid", 32'(cmd_valid), 1);
        check("t3_motor", 32'(motor_cmd), 4);
        check("t3_speed", 32'(speed_fast), 0);
        orange_detected = 1'b1;
        direction       = 3'b010;
        tick();
        tick();
        check("t3_two_ticks", 32'(mode), 2);
        tick();
        check("t3_mode_track", 32'(mode), 3);
        step();
        step();
        check("t3_track_valid", 32'(cmd_valid), 1);
        check("t3_track_motor", 32'(motor_cmd), 1);

        // Track follows direction, then loses the target
        step();
        direction = 3'b100;
        step();
        step();
        check("t4_left_valid", 32'(cmd_valid), 1);
        check("t4_left_motor", 32'(motor_cmd), 3);
        step();
        orange_detected = 1'b0;
        direction       = 3'b000;
        repeat (5) tick();
        orange_detected = 1'b1;
        tick();
        orange_detected = 1'b0;
        repeat (7) tick();
        check("t4_seven_miss", 32'(mode), 3);
        tick();
        check("t4_lost_mode", 32'(mode), 2);
        step();
        check("t4_lost_valid", 32'(cmd_valid), 1);
        check("t4_lost_motor", 32'(motor_cmd), 4);

        // Backpressure drops intermediate commands
        step();
        cmd_ready = 1'b0;
        press(3'd3);
        step();
        check("t5_mode", 32'(mode), 1);
        step();
        check("t5_valid", 32'(cmd_valid), 1);
        check("t5_motor3", 32'(motor_cmd), 3);
        press(3'd1);
        step();
        step();
        check("t5_hold_a_valid", 32'(cmd_valid), 1);
        check("t5_hold_a_motor", 32'(motor_cmd), 3);
        press(3'd4);
        step();
        step();
        check("t5_hold_b_motor", 32'(motor_cmd), 3);
        cmd_ready = 1'b1;
        step();
        check("t5_gap", 32'(cmd_valid), 0);
        step();
        check("t5_next_valid", 32'(cmd_valid), 1);
        check("t5_next_motor", 32'(motor_cmd), 4);

        // Press in the same cycle as a confirming frame wins
        step();
        press(3'd6);
        step();
        check("t6_search", 32'(mode), 2);
        orange_detected = 1'b1;
        direction       = 3'b010;
        tick();
        tick();
        check("t6_pre", 32'(mode), 2);
        press(3'd5);
        tick();
        check("t6_stop", 32'(mode), 0);
        step();
        check("t6_valid", 32'(cmd_valid), 1);
        check("t6_motor", 32'(motor_cmd), 0);
        step();
        step();
        check("t6_no_track", 32'(mode), 0);

        // Code 0 ignored, code 7 enters manual with motion stop
        press(3'd0);
        step();
        check("t7_none", 32'(mode), 0);
        press(3'd7);
        step();
        check("t7_manual", 32'(mode), 1);
        step();
        check("t7_no_cmd", 32'(cmd_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
